// File: rtl/ddr_cmd_gen.sv
// DDR4 command generator: one request at a time, per-bank open-row tracking,
// PRE/ACT/CAS sequencing with tRP, tRCD and tCCD spacing on a registered bus.
module ddr_cmd_gen #(
  parameter int T_RP  = 4,
  parameter int T_RCD = 4,
  parameter int T_CCD = 4
) (
  input  logic        CK_t,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_bg,
  input  logic [1:0]  req_ba,
  input  logic [16:0] req_row,
  input  logic [9:0]  req_col,
  input  logic        req_bl8,
  output logic        cs_n,
  output logic        act_n,
  output logic        RAS_n_A16,
  output logic        CAS_n_A15,
  output logic        WE_n_A14,
  output logic [1:0]  bg_addr,
  output logic [1:0]  ba_addr,
  output logic        A13,
  output logic        A12_BC_n,
  output logic        A11,
  output logic        A10_AP,
  output logic [9:0]  A9_A0,
  output logic        no_act_rdy,
  output logic        rd_rdy
);

  localparam int CW = 8;
  localparam logic [CW-1:0] RP_LOAD  = CW'(T_RP - 1);
  localparam logic [CW-1:0] RCD_LOAD = CW'(T_RCD - 1);
  localparam logic [CW-1:0] CCD_LOAD = CW'(T_CCD - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [4:0] CMD_DES = 5'b11111;
  localparam logic [4:0] CMD_PRE = 5'b01010;
  localparam logic [4:0] CMD_WR  = 5'b01100;
  localparam logic [4:0] CMD_RD  = 5'b01101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WAIT_RP,
    S_ACT,
    S_WAIT_RCD,
    S_CAS
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] ccd_q, ccd_d;
  logic          hit_q, hit_d;
  logic          wr_q, wr_d;
  logic [3:0]    bank_q, bank_d;
  logic [16:0]   row_q, row_d;
  logic [9:0]    col_q, col_d;
  logic          bl8_q, bl8_d;
  logic [15:0]   vld_q, vld_d;
  logic [16:0]   row_tbl_q [16];
  logic [16:0]   row_tbl_d [16];

  logic [4:0]    cmd_q, cmd_d;
  logic [16:0]   addr_q, addr_d;   // {A16..A14 overlay, A13, A12, A11, A10, A9..A0}
  logic [3:0]    bgba_q, bgba_d;
  logic          req_ready_q, req_ready_d;
  logic          no_act_rdy_q, no_act_rdy_d;
  logic          rd_rdy_q, rd_rdy_d;

  logic [3:0]    req_bank;
  assign req_bank = {req_bg, req_ba};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ccd_d        = (ccd_q != '0) ? ccd_q - CNT_ONE : '0;
    hit_d        = hit_q;
    wr_d         = wr_q;
    bank_d       = bank_q;
    row_d        = row_q;
    col_d        = col_q;
    bl8_d        = bl8_q;
    vld_d        = vld_q;
    row_tbl_d    = row_tbl_q;
    cmd_d        = CMD_DES;
    addr_d       = '0;
    bgba_d       = '0;
    no_act_rdy_d = 1'b0;
    rd_rdy_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          wr_d   = req_wr;
          bank_d = req_bank;
          row_d  = req_row;
          col_d  = req_col;
          bl8_d  = req_bl8;
          hit_d  = 1'b0;
          if (!vld_q[req_bank]) begin
            state_d = S_ACT;
          end else if (row_tbl_q[req_bank] == req_row) begin
            state_d = S_CAS;
            hit_d   = 1'b1;
          end else begin
            state_d = S_PRE;
          end
        end
      end
      S_PRE: begin
        cmd_d         = CMD_PRE;
        bgba_d        = bank_q;
        vld_d[bank_q] = 1'b0;
        cnt_d         = RP_LOAD;
        state_d       = (T_RP > 1) ? S_WAIT_RP : S_ACT;
      end
      // Leaving on the cycle the decrement reaches zero keeps PRE->ACT at exactly T_RP.
      S_WAIT_RP: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q <= CNT_ONE) state_d = S_ACT;
      end
      S_ACT: begin
        cmd_d             = {2'b00, row_q[16:14]};
        addr_d            = row_q;
        bgba_d            = bank_q;
        vld_d[bank_q]     = 1'b1;
        row_tbl_d[bank_q] = row_q;
        cnt_d             = RCD_LOAD;
        state_d           = (T_RCD > 1) ? S_WAIT_RCD : S_CAS;
      end
      S_WAIT_RCD: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q <= CNT_ONE) state_d = S_CAS;
      end
      S_CAS: begin
        if (ccd_q == '0) begin
          cmd_d        = wr_q ? CMD_WR : CMD_RD;
          bgba_d       = bank_q;
          addr_d       = {5'b00000, bl8_q, 1'b0, 1'b0, col_q};
          rd_rdy_d     = !wr_q;
          no_act_rdy_d = hit_q;
          ccd_d        = CCD_LOAD;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    req_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      ccd_q        <= '0;
      hit_q        <= 1'b0;
      wr_q         <= 1'b0;
      bank_q       <= '0;
      row_q        <= '0;
      col_q        <= '0;
      bl8_q        <= 1'b0;
      vld_q        <= '0;
      for (int unsigned i = 0; i < 16; i++) row_tbl_q[i] <= '0;
      cmd_q        <= CMD_DES;
      addr_q       <= '0;
      bgba_q       <= '0;
      req_ready_q  <= 1'b1;
      no_act_rdy_q <= 1'b0;
      rd_rdy_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ccd_q        <= ccd_d;
      hit_q        <= hit_d;
      wr_q         <= wr_d;
      bank_q       <= bank_d;
      row_q        <= row_d;
      col_q        <= col_d;
      bl8_q        <= bl8_d;
      vld_q        <= vld_d;
      row_tbl_q    <= row_tbl_d;
      cmd_q        <= cmd_d;
      addr_q       <= addr_d;
      bgba_q       <= bgba_d;
      req_ready_q  <= req_ready_d;
      no_act_rdy_q <= no_act_rdy_d;
      rd_rdy_q     <= rd_rdy_d;
    end
  end

  assign cs_n       = cmd_q[4];
  assign act_n      = cmd_q[3];
  assign RAS_n_A16  = cmd_q[2];
  assign CAS_n_A15  = cmd_q[1];
  assign WE_n_A14   = cmd_q[0];
  assign bg_addr    = bgba_q[3:2];
  assign ba_addr    = bgba_q[1:0];
  assign A13        = addr_q[13];
  assign A12_BC_n   = addr_q[12];
  assign A11        = addr_q[11];
  assign A10_AP     = addr_q[10];
  assign A9_A0      = addr_q[9:0];
  assign req_ready  = req_ready_q;
  assign no_act_rdy = no_act_rdy_q;
  assign rd_rdy     = rd_rdy_q;

endmodule

// File: tb/tb_ddr_cmd_gen.sv
// Self-checking bench for ddr_cmd_gen: randomized requests against a
// cycle-timed command model built from the timing rules.
module tb_ddr_cmd_gen;

  localparam int T_RP  = 4;
  localparam int T_RCD = 4;
  localparam int T_CCD = 4;

  logic        CK_t = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [1:0]  req_bg = '0;
  logic [1:0]  req_ba = '0;
  logic [16:0] req_row = '0;
  logic [9:0]  req_col = '0;
  logic        req_bl8 = 1'b0;
  logic        cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14;
  logic [1:0]  bg_addr, ba_addr;
  logic        A13, A12_BC_n, A11, A10_AP;
  logic [9:0]  A9_A0;
  logic        no_act_rdy, rd_rdy;

  ddr_cmd_gen #(.T_RP(T_RP), .T_RCD(T_RCD), .T_CCD(T_CCD)) dut (
    .CK_t(CK_t), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
    .req_bl8(req_bl8),
    .cs_n(cs_n), .act_n(act_n), .RAS_n_A16(RAS_n_A16), .CAS_n_A15(CAS_n_A15),
    .WE_n_A14(WE_n_A14), .bg_addr(bg_addr), .ba_addr(ba_addr),
    .A13(A13), .A12_BC_n(A12_BC_n), .A11(A11), .A10_AP(A10_AP), .A9_A0(A9_A0),
    .no_act_rdy(no_act_rdy), .rd_rdy(rd_rdy)
  );

  always #5 CK_t = ~CK_t;

  int cyc = 0;
  always @(posedge CK_t) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Reference model: open rows per bank and the edge of the last CAS.
  typedef struct {
    int          cyc;
    int          kind;   // 0 PRE, 1 ACT, 2 CAS
    logic [3:0]  bank;
    logic [16:0] row;
    logic [9:0]  col;
    logic        wr;
    logic        bl8;
    logic        hit;
  } exp_t;

  exp_t        exp_q[$];
  logic        m_vld [16];
  logic [16:0] m_row [16];
  int          last_cas = -1000;

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_vld[i] = 1'b0;
      m_row[i] = '0;
    end
    last_cas = -1000;
    exp_q.delete();
  endtask

  task automatic model_accept(input int a, input logic wr, input logic [3:0] b,
                              input logic [16:0] row, input logic [9:0] col, input logic bl8);
    exp_t e;
    int   cas_at;
    e.bank = b; e.row = row; e.col = col; e.wr = wr; e.bl8 = bl8; e.hit = 1'b0;
    if (m_vld[b] && m_row[b] == row) begin
      cas_at = a + 1;
      e.hit  = 1'b1;
    end else if (!m_vld[b]) begin
      e.kind = 1; e.cyc = a + 1; exp_q.push_back(e);
      cas_at = a + 1 + T_RCD;
    end else begin
      e.kind = 0; e.cyc = a + 1; exp_q.push_back(e);
      e.kind = 1; e.cyc = a + 1 + T_RP; exp_q.push_back(e);
      cas_at = a + 1 + T_RP + T_RCD;
    end
    if (last_cas + T_CCD > cas_at) cas_at = last_cas + T_CCD;
    e.kind = 2; e.cyc = cas_at; exp_q.push_back(e);
    last_cas = cas_at;
    m_vld[b] = 1'b1;
    m_row[b] = row;
  endtask

  // Bus monitor: every non-DES cycle must match the head of the expected list.
  exp_t        mon_e;
  logic [16:0] mon_addr;
  always @(negedge CK_t) begin
    if (reset_n) begin
      mon_addr = {RAS_n_A16, CAS_n_A15, WE_n_A14, A13, A12_BC_n, A11, A10_AP, A9_A0};
      if (!cs_n) begin
        if (exp_q.size() == 0) begin
          check("unexpected_cmd", {27'd0, cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14}, 32'h1f);
        end else begin
          mon_e = exp_q.pop_front();
          check("cmd_cycle", cyc, mon_e.cyc);
          check("cmd_bank", {28'd0, bg_addr, ba_addr}, {28'd0, mon_e.bank});
          case (mon_e.kind)
            0: begin
              check("pre_cmd", {27'd0, cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14}, 32'h0a);
              check("pre_a10", A10_AP, 0);
            end
            1: begin
              check("act_pins", {30'd0, cs_n, act_n}, 0);
              check("act_row", mon_addr, mon_e.row);
            end
            default: begin
              check("cas_cmd", {27'd0, cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14},
                    mon_e.wr ? 32'h0c : 32'h0d);
              check("cas_col", A9_A0, mon_e.col);
              check("cas_a13_a10", {A13, A12_BC_n, A11, A10_AP}, {1'b0, mon_e.bl8, 2'b00});
            end
          endcase
          check("rd_rdy", rd_rdy, (mon_e.kind == 2) && !mon_e.wr);
          check("no_act_rdy", no_act_rdy, (mon_e.kind == 2) && mon_e.hit);
        end
      end else if (rd_rdy || no_act_rdy) begin
        check("stray_pulse", {30'd0, rd_rdy, no_act_rdy}, 0);
      end
    end
  end

  task automatic check_idle_bus(input string tag);
    check({tag, "_cmd"}, {27'd0, cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14}, 32'h1f);
    check({tag, "_addr"}, {bg_addr, ba_addr, A13, A12_BC_n, A11, A10_AP, A9_A0}, 0);
    check({tag, "_ready"}, req_ready, 1);
    check({tag, "_pulses"}, {rd_rdy, no_act_rdy}, 0);
  endtask

  task automatic apply_reset();
    @(negedge CK_t);
    req_valid = 1'b0;
    reset_n   = 1'b0;
    #1 check_idle_bus("reset");
    model_clear();
    repeat (2) @(negedge CK_t);
    reset_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CK_t);
      req_valid = 1'b0;
    end
  endtask

  // Offers a request; while busy, either holds it or scrambles the fields.
  task automatic send(input logic wr, input logic [3:0] b, input logic [16:0] row,
                      input logic [9:0] col, input logic bl8, input bit scramble);
    int  waited = 0;
    bit  done   = 0;
    int  acc;
    while (!done) begin
      @(negedge CK_t);
      req_valid = 1'b1;
      if (req_ready) begin
        req_wr = wr; req_bg = b[3:2]; req_ba = b[1:0];
        req_row = row; req_col = col; req_bl8 = bl8;
        acc = cyc + 1;
        @(posedge CK_t);
        model_accept(acc, wr, b, row, col, bl8);
        done = 1;
      end else begin
        if (scramble) begin
          req_wr  = 1'($urandom);  req_bg = 2'($urandom); req_ba = 2'($urandom);
          req_row = 17'($urandom); req_col = 10'($urandom); req_bl8 = 1'($urandom);
        end else begin
          req_wr = wr; req_bg = b[3:2]; req_ba = b[1:0];
          req_row = row; req_col = col; req_bl8 = bl8;
        end
        waited++;
        if (waited > 100) begin
          check("accept_timeout", 0, 1);
          done = 1;
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [16:0] rows [16];
  logic [16:0] alt  [16];

  initial begin
    model_clear();
    repeat (3) @(negedge CK_t);
    #1 check_idle_bus("por");
    @(negedge CK_t);
    reset_n = 1'b1;

    // Directed: miss to empty bank, back-to-back hit, then conflict write.
    send(1'b0, 4'h6, 17'h1ABCD, 10'h040, 1'b1, 0);
    send(1'b0, 4'h6, 17'h1ABCD, 10'h048, 1'b1, 0);
    send(1'b1, 4'h6, 17'h00010, 10'h155, 1'b0, 1);
    idle(12);

    // Reset during WAIT_RCD, then the same bank must re-open with ACT.
    send(1'b0, 4'h3, 17'h0F0F0, 10'h011, 1'b1, 0);
    repeat (3) @(negedge CK_t);
    req_valid = 1'b0;
    reset_n   = 1'b0;
    #1 check_idle_bus("midrst");
    model_clear();
    repeat (2) @(negedge CK_t);
    reset_n = 1'b1;
    send(1'b0, 4'h3, 17'h0F0F0, 10'h022, 1'b1, 0);
    idle(12);

    // All 16 banks opened, then revisited as hits.
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      rows[i] = 17'($urandom);
      alt[i]  = rows[i] ^ 17'(1 + $urandom_range(0, 1000));
    end
    for (int i = 0; i < 16; i++)
      send(1'($urandom), 4'(i), rows[i], 10'($urandom), 1'($urandom), 0);
    for (int i = 0; i < 16; i++)
      send(1'($urandom), 4'(i), rows[i], 10'($urandom), 1'($urandom), 1);
    idle(10);

    // Random mix of hits, misses and conflicts with random gaps.
    for (int n = 0; n < 200; n++) begin
      int unsigned b;
      b = $urandom_range(0, 15);
      send(1'($urandom), 4'(b), ($urandom_range(0, 1) != 0) ? rows[b] : alt[b],
           10'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(20);

    check("exp_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
